// File: rtl/sdram_stream_pkg.sv
// Definitions shared by the SDRAM stream reader and writer: instruction layout,
// length decode and the request-engine state encoding.
package sdram_stream_pkg;

  localparam int unsigned INSTR_ADDR_MSB = 31;
  localparam int unsigned INSTR_ADDR_LSB = 8;
  localparam int unsigned INSTR_LEN_MSB  = 7;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } stream_state_e;

  // A zero length field encodes a full run of 256 words.
  function automatic logic [8:0] decode_len(input logic [7:0] len);
    return (len == 8'd0) ? 9'd256 : {1'b0, len};
  endfunction

endpackage

// File: rtl/sdram_read_fifo.sv
// Show-ahead FIFO buffering SDRAM read returns; rd_data always presents the head
// entry, and count reports occupancy.
module sdram_read_fifo #(
  parameter int unsigned Width = 257,
  parameter int unsigned Depth = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [Width-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [Width-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned PtrWidth = $clog2(Depth);

  logic [Width-1:0]  mem [Depth];
  logic [PtrWidth:0] wptr_q, rptr_q;
  logic              do_wr, do_rd;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count   = wptr_q - rptr_q;
  assign empty   = (count == '0);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (count != (PtrWidth + 1)'(Depth));
  assign rd_data = mem[rptr_q[PtrWidth-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + 1'b1;
      if (do_rd) rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_wr) mem[wptr_q[PtrWidth-1:0]] <= wr_data;
  end

endmodule

// File: rtl/sdram_read_to_avalon_st.sv
// Fetches a run of words from SDRAM with bursting Avalon-MM reads and replays them
// as an Avalon-ST stream, marking the final word of each run with st_last.
module sdram_read_to_avalon_st
  import sdram_stream_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 27,
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned MAX_BURST  = 8,
  parameter int unsigned FIFO_DEPTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  st_instruction_valid,
  output logic                  st_instruction_ready,
  input  logic [31:0]           st_instruction_data,
  output logic [ADDR_WIDTH-1:0] mm_addr,
  output logic [7:0]            mm_burstcount,
  output logic                  mm_read,
  input  logic                  mm_waitrequest,
  input  logic                  mm_readdatavalid,
  input  logic [DATA_WIDTH-1:0] mm_readdata,
  output logic                  st_valid,
  input  logic                  st_ready,
  output logic [DATA_WIDTH-1:0] st_data,
  output logic                  st_last
);

  localparam int unsigned CntWidth = $clog2(FIFO_DEPTH) + 1;

  stream_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [8:0]            remaining_q, remaining_d, total_q, total_d, rx_count_q, rx_count_d;
  logic [CntWidth-1:0]   outstanding_q, outstanding_d, fifo_count;
  logic                  gap_q, gap_d;
  logic [8:0]            burst;
  logic [CntWidth:0]     committed;
  logic                  can_issue, req_accept, ret_word, ret_last, fifo_empty;
  logic [DATA_WIDTH:0]   fifo_head;

  assign burst     = (remaining_q > 9'(MAX_BURST)) ? 9'(MAX_BURST) : remaining_q;
  // Words already buffered plus words still in flight must leave room for the burst.
  assign committed = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign can_issue = (committed + (CntWidth + 1)'(burst)) <= (CntWidth + 1)'(FIFO_DEPTH);

  assign mm_read       = (state_q == StIssue) && !gap_q && can_issue;
  assign mm_addr       = mm_read ? addr_q : '0;
  assign mm_burstcount = mm_read ? burst[7:0] : '0;
  assign req_accept    = mm_read && !mm_waitrequest;

  assign st_instruction_ready = (state_q == StIdle);
  // Stale returns after a reset arrive with nothing outstanding and are dropped.
  assign ret_word = mm_readdatavalid && (outstanding_q != '0);
  assign ret_last = ((rx_count_q + 9'd1) == total_q);

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    total_d       = total_q;
    rx_count_d    = rx_count_q;
    gap_d         = 1'b0;
    outstanding_d = outstanding_q + (req_accept ? CntWidth'(burst) : '0)
                    - CntWidth'(ret_word);
    if (ret_word) rx_count_d = rx_count_q + 9'd1;
    unique case (state_q)
      StIdle: begin
        if (st_instruction_valid) begin
          addr_d      = ADDR_WIDTH'(st_instruction_data[INSTR_ADDR_MSB:INSTR_ADDR_LSB]);
          remaining_d = decode_len(st_instruction_data[INSTR_LEN_MSB:0]);
          total_d     = decode_len(st_instruction_data[INSTR_LEN_MSB:0]);
          rx_count_d  = '0;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        if (req_accept) begin
          addr_d      = addr_q + ADDR_WIDTH'(burst);
          remaining_d = remaining_q - burst;
          gap_d       = 1'b1;
          if (remaining_q == burst) state_d = StWait;
        end
      end
      StWait: begin
        if (outstanding_q == '0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      remaining_q   <= '0;
      total_q       <= '0;
      rx_count_q    <= '0;
      outstanding_q <= '0;
      gap_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      total_q       <= total_d;
      rx_count_q    <= rx_count_d;
      outstanding_q <= outstanding_d;
      gap_q         <= gap_d;
    end
  end

  sdram_read_fifo #(
    .Width (DATA_WIDTH + 1),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (ret_word),
    .wr_data ({ret_last, mm_readdata}),
    .rd_en   (st_valid && st_ready),
    .rd_data (fifo_head),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign st_valid = !fifo_empty;
  assign st_data  = st_valid ? fifo_head[DATA_WIDTH-1:0] : '0;
  assign st_last  = st_valid && fifo_head[DATA_WIDTH];

endmodule

// File: tb/tb_sdram_read_to_avalon_st.sv
// Directed bench: a vector table of runs against a zero-latency slave model,
// plus hand-written backpressure and mid-run reset sequences.
module tb_sdram_read_to_avalon_st;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         st_instruction_valid = 1'b0;
  logic         st_instruction_ready;
  logic [31:0]  st_instruction_data = '0;
  logic [26:0]  mm_addr;
  logic [7:0]   mm_burstcount;
  logic         mm_read;
  logic         mm_waitrequest = 1'b0;
  logic         mm_readdatavalid = 1'b0;
  logic [255:0] mm_readdata = '0;
  logic         st_valid;
  logic         st_ready = 1'b0;
  logic [255:0] st_data;
  logic         st_last;

  sdram_read_to_avalon_st dut (
    .clock                (clock),
    .reset                (reset),
    .st_instruction_valid (st_instruction_valid),
    .st_instruction_ready (st_instruction_ready),
    .st_instruction_data  (st_instruction_data),
    .mm_addr              (mm_addr),
    .mm_burstcount        (mm_burstcount),
    .mm_read              (mm_read),
    .mm_waitrequest       (mm_waitrequest),
    .mm_readdatavalid     (mm_readdatavalid),
    .mm_readdata          (mm_readdata),
    .st_valid             (st_valid),
    .st_ready             (st_ready),
    .st_data              (st_data),
    .st_last              (st_last)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [23:0]  base;
    logic [7:0]   cnt;
    logic [255:0] data_base;
    int           words;
    int           bursts;
    int           last_bc;
    int           wait_cycles;
    bit           ready_toggle;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Slave / stream model state.
  logic [255:0] ret_q[$];
  bit           slave_en = 1'b1;
  bit           ready_en = 1'b1;
  bit           ready_toggle = 1'b0;
  int           wait_left = 0;
  logic [26:0]  cur_base, exp_addr;
  logic [255:0] cur_db;
  int           exp_words, rem, rx_idx, bursts, last_bc, issued, consumed;
  int           first_req_cycles;
  bit           first_done;
  bit           prev_stall, prev_wait;
  logic [255:0] prev_data;
  logic         prev_last;
  logic [26:0]  prev_addr;
  logic [7:0]   prev_bc;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic start_model(input logic [23:0] base, input logic [7:0] cnt,
                             input logic [255:0] db);
    cur_base   = 27'(base);
    exp_addr   = 27'(base);
    cur_db     = db;
    exp_words  = (cnt == 8'd0) ? 256 : int'(cnt);
    rem        = exp_words;
    rx_idx     = 0;
    bursts     = 0;
    last_bc    = 0;
    issued     = 0;
    consumed   = 0;
    first_done = 1'b0;
    first_req_cycles = 0;
    prev_stall = 1'b0;
    prev_wait  = 1'b0;
  endtask

  // Drive slave/stream inputs at negedge, then sample the settled cycle at +1.
  initial begin
    forever begin
      @(negedge clock);
      if (slave_en && ret_q.size() > 0) begin
        mm_readdatavalid = 1'b1;
        mm_readdata      = ret_q.pop_front();
      end else begin
        mm_readdatavalid = 1'b0;
        mm_readdata      = '0;
      end
      mm_waitrequest = (wait_left > 0);
      st_ready = ready_toggle ? ~st_ready : ready_en;
      #1;
      if (prev_stall) begin
        chk("st_hold_valid", st_valid, 1'b1);
        chk("st_hold_data", st_data, prev_data);
        chk("st_hold_last", st_last, prev_last);
      end
      prev_stall = st_valid && !st_ready;
      prev_data  = st_data;
      prev_last  = st_last;
      if (prev_wait) begin
        chk("req_hold_read", mm_read, 1'b1);
        chk("req_hold_addr", mm_addr, prev_addr);
        chk("req_hold_bc", mm_burstcount, prev_bc);
      end
      prev_wait = mm_read && mm_waitrequest;
      prev_addr = mm_addr;
      prev_bc   = mm_burstcount;
      if (mm_read) begin
        if (!first_done) first_req_cycles++;
        if (mm_waitrequest) begin
          if (wait_left > 0) wait_left--;
        end else begin
          int bc;
          logic [26:0] off;
          bc = (rem > 8) ? 8 : rem;
          chk("burst_addr", mm_addr, exp_addr);
          chk("burst_count", mm_burstcount, bc);
          chk("free_space", (issued - consumed + bc) <= 32, 1'b1);
          off = mm_addr - cur_base;
          for (int j = 0; j < int'(mm_burstcount); j++) ret_q.push_back(cur_db + off + j);
          exp_addr   = exp_addr + 27'(bc);
          rem        = rem - bc;
          issued     = issued + bc;
          bursts++;
          last_bc    = bc;
          first_done = 1'b1;
        end
      end
      if (st_valid && st_ready) begin
        chk("st_data", st_data, cur_db + rx_idx);
        chk("st_last", st_last, rx_idx == exp_words - 1);
        rx_idx++;
        consumed++;
      end
    end
  end

  task automatic issue(input logic [23:0] base, input logic [7:0] cnt);
    int n = 0;
    @(negedge clock); #2;
    st_instruction_valid = 1'b1;
    st_instruction_data  = {base, cnt};
    while (!st_instruction_ready && n < 100) begin
      @(negedge clock); #2;
      n++;
    end
    chk("instr_ready", st_instruction_ready, 1'b1);
    @(negedge clock); #2;
    st_instruction_valid = 1'b0;
    chk("first_req", mm_read, 1'b1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(rx_idx == exp_words && st_instruction_ready && !st_valid) && n < 4000) begin
      @(negedge clock); #2;
      n++;
    end
    chk("run_done", n < 4000, 1'b1);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock); #2;
    end
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{24'h000100, 8'd3,  256'hA0,   3,   1,  3, 0, 1'b0};
    vecs[1] = '{24'h000200, 8'd20, 256'h1000, 20,  3,  4, 0, 1'b1};
    vecs[2] = '{24'h001000, 8'd0,  256'h5000, 256, 32, 8, 0, 1'b0};
    vecs[3] = '{24'h000040, 8'd5,  256'h77,   5,   1,  5, 3, 1'b0};
    vecs[4] = '{24'hFFFFFC, 8'd12, 256'h900,  12,  2,  4, 0, 1'b1};

    start_model(24'h0, 8'd1, '0);
    #1;
    chk("rst_instr_ready", st_instruction_ready, 1'b1);
    chk("rst_mm_read", mm_read, 1'b0);
    chk("rst_st_valid", st_valid, 1'b0);
    chk("rst_st_last", st_last, 1'b0);
    chk("rst_st_data", st_data, '0);
    chk("rst_mm_addr", mm_addr, '0);
    chk("rst_mm_bc", mm_burstcount, '0);
    cycles(3);
    reset = 1'b0;
    cycles(2);

    for (int v = 0; v < 5; v++) begin
      start_model(vecs[v].base, vecs[v].cnt, vecs[v].data_base);
      ready_toggle = vecs[v].ready_toggle;
      ready_en     = 1'b1;
      wait_left    = vecs[v].wait_cycles;
      issue(vecs[v].base, vecs[v].cnt);
      wait_done();
      chk("words", rx_idx, vecs[v].words);
      chk("bursts", bursts, vecs[v].bursts);
      chk("last_burstcount", last_bc, vecs[v].last_bc);
      chk("req_cycles", first_req_cycles, vecs[v].wait_cycles + 1);
      ready_toggle = 1'b0;
      cycles(2);
    end

    // Backpressure: nothing consumed, so issue must stop at FIFO_DEPTH words.
    start_model(24'h002000, 8'd64, 256'h3000);
    ready_en = 1'b0;
    issue(24'h002000, 8'd64);
    cycles(80);
    chk("stall_issued", issued, 32);
    chk("stall_bursts", bursts, 4);
    chk("stall_valid", st_valid, 1'b1);
    chk("stall_head", st_data, 256'h3000);
    ready_en = 1'b1;
    wait_done();
    chk("stall_words", rx_idx, 64);
    chk("stall_total_bursts", bursts, 8);

    // Mid-run reset with stale returns arriving afterwards.
    start_model(24'h000300, 8'd16, 256'h600);
    ready_en = 1'b0;
    issue(24'h000300, 8'd16);
    cycles(4);
    chk("pre_reset_valid", st_valid, 1'b1);
    @(negedge clock); #3;
    reset    = 1'b1;
    slave_en = 1'b0;
    ret_q.delete();
    ret_q.push_back(256'hDEAD0);
    ret_q.push_back(256'hDEAD1);
    #1;
    chk("async_rst_valid", st_valid, 1'b0);
    chk("async_rst_read", mm_read, 1'b0);
    chk("async_rst_ready", st_instruction_ready, 1'b1);
    chk("async_rst_last", st_last, 1'b0);
    start_model(24'h0, 8'd1, '0);
    cycles(2);
    @(negedge clock); #3;
    reset    = 1'b0;
    slave_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycles(1);
      chk("stale_valid", st_valid, 1'b0);
      chk("stale_ready", st_instruction_ready, 1'b1);
    end
    start_model(24'h000400, 8'd2, 256'hB0);
    ready_en = 1'b1;
    issue(24'h000400, 8'd2);
    wait_done();
    chk("post_rst_words", rx_idx, 2);
    chk("post_rst_bursts", bursts, 1);
    cycles(5);
    chk("post_rst_no_extra", rx_idx, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_read_to_avalon_st.md
# sdram_read_to_avalon_st

Reads a contiguous run of 256-bit words from SDRAM over an Avalon-MM bursting read master and presents them as an Avalon-ST stream with end-of-run marking. It is the upstream mirror of the stream-to-SDRAM writer: it fetches weights and activations from DRAM and feeds the compute/write path. It accepts one 32-bit instruction per run, splits the run into bursts of at most MAX_BURST words, and buffers the returned data in an internal FIFO. A burst is issued only when the FIFO is guaranteed to hold every word it returns.

## Interface
- ADDR_WIDTH, 27: width of mm_addr, in 256-bit word units.
- DATA_WIDTH, 256: width of the data path.
- MAX_BURST, 8: largest mm_burstcount issued; power of 2, ≤ 128.
- FIFO_DEPTH, 32: read-buffer depth in words; power of 2, ≥ MAX_BURST.

Ports:
- clock  in  1  single clock; all logic rises on posedge clock.
- reset  in  1  asynchronous, active-high reset.
- st_instruction_valid  in  1  instruction offered.
- st_instruction_ready  out  1  high only in IDLE.
- st_instruction_data  in  32  bits [31:8] = base word address, zero-extended to ADDR_WIDTH; bits [7:0] = word count, where 0 means 256.
- mm_addr  out  ADDR_WIDTH  burst start address.
- mm_burstcount  out  8  words in the current burst.
- mm_read  out  1  read request.
- mm_waitrequest  in  1  slave stall.
- mm_readdatavalid  in  1  return word valid.
- mm_readdata  in  DATA_WIDTH  return word.
- st_valid  out  1  st_data is valid; equals "FIFO not empty".
- st_ready  in  1  consumer accepts the current word.
- st_data  out  DATA_WIDTH  head word of the FIFO.
- st_last  out  1  marks the final word of a run.

## Operation
- State machine states are IDLE, ISSUE and WAIT. Reset enters IDLE.
- **IDLE**
  - st_instruction_ready is 1.
  - On valid&ready: latch addr = base, remaining = count, total = count, rx_count = 0, then go to ISSUE.
- **ISSUE**
  - burst = min(remaining, MAX_BURST).
  - free = FIFO_DEPTH − fifo_count − outstanding.
  - If free ≥ burst, drive mm_read=1 with mm_addr=addr and mm_burstcount=burst, and hold these constant while mm_waitrequest=1.
  - On the cycle where mm_read=1 and mm_waitrequest=0: addr += burst, remaining −= burst, outstanding += burst, and deassert mm_read the next cycle.
  - The block recomputes burst and free before the next request, so back-to-back requests have at least one idle cycle between them.
  - Go to WAIT when remaining reaches 0.
- **WAIT**
  - When outstanding = 0, go to IDLE.
  - The FIFO may still hold words from this run. A new instruction may be accepted while the FIFO drains.
- **Return path**
  - Each word with mm_readdatavalid=1 and outstanding > 0 is written to the FIFO with a last bit set when rx_count+1 = total. Then rx_count is incremented and outstanding is decremented.
  - mm_readdatavalid is ignored when outstanding = 0; this covers stale data arriving after a reset.
- **Counter widths**
  - outstanding and fifo_count are log2(FIFO_DEPTH)+1 bits.
  - remaining, total and rx_count are 9 bits, to hold 256.
  - Address arithmetic wraps modulo 2^ADDR_WIDTH.
- **FIFO bookkeeping**
  - A simultaneous FIFO write and read leaves fifo_count unchanged.
  - The free-space calculation never goes negative; the FIFO never overflows by construction.

## Timing
- Reset values of all outputs are 0, except st_instruction_ready = 1 after reset in IDLE. FIFO pointers, counters and state are cleared.
- Instruction accepted at edge E → first mm_read=1 in the cycle after E, provided free ≥ burst.
- mm_readdatavalid high in cycle N → that word appears on st_data with st_valid=1 in cycle N+1 if the FIFO was empty. Latency is 1 cycle.
- The stream side follows the rule "transfer when st_valid & st_ready". st_data, st_valid and st_last are stable while st_valid=1 and st_ready=0.
- Sustained throughput is 1 word/cycle when mm_readdatavalid streams and st_ready=1.
- Reset asserted mid-run: all outputs return to their reset values asynchronously, buffered data is discarded, and no st_last is produced for the aborted run.

## Structure
- Shared package (sdram_stream_pkg), shared with the writer:
  - instruction field positions/widths: INSTR_ADDR_MSB=31, INSTR_ADDR_LSB=8, INSTR_LEN_MSB=7;
  - a length-decode function (0 → 256);
  - an enum for the IDLE/ISSUE/WAIT states.
- One sub-module, sdram_read_fifo:
  - synchronous show-ahead FIFO, DATA_WIDTH+1 bits wide (the extra bit carries last), FIFO_DEPTH deep;
  - exposes a count output;
  - asynchronous active-high reset on the same clock/reset.

## Test plan
- Instruction with base 0x000100 and count 3, st_ready=1, zero-latency slave returning 0xA0..0xA2 → one burst (addr 0x100, burstcount 3). Stream outputs A0, A1, A2, with st_last only on A2.
- Count 20, MAX_BURST 8 → bursts at addr+0, +8 and +16 with burstcount 8, 8 and 4. 20 words out in order; st_last on the 20th.
- Count field 0 → 256 words read in 32 bursts; st_last on word 256; address increments by 8 per burst.
- st_ready=0 throughout with count 64, FIFO_DEPTH 32 → requests stop once 32 words are buffered or outstanding. Releasing st_ready resumes issue; no word is lost or duplicated.
- mm_waitrequest high for 3 cycles on the first request → mm_read, mm_addr and mm_burstcount stay constant for 4 cycles and the request is counted once.
- Reset pulsed mid-burst, with 2 stale mm_readdatavalid words arriving afterwards → st_valid stays 0 and st_instruction_ready=1. A subsequent instruction with count 2 yields exactly 2 words.
